// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port data RAM between the CPU memory stage and the camera DMA
// Optional starvation guard for CAM: define RAM_ARBITER_STARVE_GUARD_EN (default build is strict CPU priority).
module ram_arbiter #(
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          cam_req,
  input  logic          cam_we,
  input  logic [AW-1:0] cam_addr,
  input  logic [31:0]   cam_wdata,
  output logic          cam_gnt,
  output logic [31:0]   cam_rdata,
  output logic          cam_rvalid,
  output logic [AW-1:0] ram_address,
  output logic [31:0]   ram_data,
  output logic          ram_wren,
  input  logic [31:0]   ram_q
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_CAM  = 2'd2
  } own_t;

  own_t        rd_own;
  logic [31:0] cpu_rdata_q;
  logic [31:0] cam_rdata_q;
  logic        force_cam;
  logic        cpu_win;
  logic        cam_win;

`ifdef RAM_ARBITER_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  // Counts consecutive cycles CAM asked and lost; saturates so force_cam stays up until CAM wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!cam_req || cam_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign force_cam = (starve_cnt == LIMIT);
`else
  assign force_cam = 1'b0;
`endif

  // Winners are gated by reset so nothing reaches the RAM while the arbiter is held.
  always_comb begin
    cam_win     = reset && cam_req && (force_cam || !cpu_req);
    cpu_win     = reset && cpu_req && !cam_win;
    cam_gnt     = cam_win;
    cpu_stall   = cpu_req && cam_win;
    ram_address = cam_win ? cam_addr  : cpu_addr;
    ram_data    = cam_win ? cam_wdata : cpu_wdata;
    ram_wren    = (cam_win && cam_we) || (cpu_win && cpu_we);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_own      <= OWN_NONE;
      cpu_rdata_q <= '0;
      cam_rdata_q <= '0;
    end else begin
      if (cpu_win && !cpu_we) begin
        rd_own <= OWN_CPU;
      end else if (cam_win && !cam_we) begin
        rd_own <= OWN_CAM;
      end else begin
        rd_own <= OWN_NONE;
      end
      if (rd_own == OWN_CPU) begin
        cpu_rdata_q <= ram_q;
      end
      if (rd_own == OWN_CAM) begin
        cam_rdata_q <= ram_q;
      end
    end
  end

  // The RAM's q is steered straight through in the return cycle; the held copy covers idle cycles.
  assign cpu_rvalid = (rd_own == OWN_CPU);
  assign cam_rvalid = (rd_own == OWN_CAM);
  assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
  assign cam_rdata  = cam_rvalid ? ram_q : cam_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM and arbitration model
// Follows RAM_ARBITER_STARVE_GUARD_EN to pick the expected arbitration policy.
module tb_ram_arbiter;
  localparam int AW    = 32;
  localparam int LIMIT = 8;
`ifdef RAM_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cam_req, cam_we;
  logic [AW-1:0] cpu_addr, cam_addr;
  logic [31:0]   cpu_wdata, cam_wdata;
  logic          cpu_stall, cpu_rvalid, cam_gnt, cam_rvalid, ram_wren;
  logic [31:0]   cpu_rdata, cam_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  ram_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
    .cam_gnt(cam_gnt), .cam_rdata(cam_rdata), .cam_rvalid(cam_rvalid),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
      ram_q <= ram_mem[ram_address[7:0]];
    end
  end

  typedef struct { int due; logic [31:0] data; } rd_t;
  typedef struct { int due; bit stall; bit gnt; bit wren; } gt_t;

  rd_t         exp_cpu[$];
  rd_t         exp_cam[$];
  gt_t         exp_g[$];
  logic [31:0] m_mem [256];
  int          m_wait = 0;
  int          last_win = 0;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  bit          rst_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: who gets the RAM this cycle, what it drives, and what each read must return.
  task automatic model();
    bit  force_c;
    int  win;
    gt_t g;
    rd_t r;
    win = 0;
    if (reset) begin
      force_c = GUARD && cam_req && (m_wait >= LIMIT);
      if (cam_req && (force_c || !cpu_req)) win = 2;
      else if (cpu_req) win = 1;
    end
    g.due   = cyc;
    g.gnt   = (win == 2);
    g.stall = cpu_req && (win == 2);
    g.wren  = (win == 1) ? cpu_we : (win == 2) ? cam_we : 1'b0;
    exp_g.push_back(g);
    last_win = win;
    if (!reset || win == 2 || !cam_req) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
    if (win == 1) begin
      if (cpu_we) m_mem[cpu_addr[7:0]] = cpu_wdata;
      else begin r.due = cyc + 1; r.data = m_mem[cpu_addr[7:0]]; exp_cpu.push_back(r); end
    end else if (win == 2) begin
      if (cam_we) m_mem[cam_addr[7:0]] = cam_wdata;
      else begin r.due = cyc + 1; r.data = m_mem[cam_addr[7:0]]; exp_cam.push_back(r); end
    end
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                       input bit kr, input bit kw, input logic [7:0] ka, input logic [31:0] kd);
    @(posedge clk);
    #1;
    if (reset && !rst_val) begin
      exp_cpu.delete();
      exp_cam.delete();
      m_wait = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
    end
    reset     = rst_val;
    cpu_req   = cr; cpu_we = cw; cpu_addr = {24'd0, ca}; cpu_wdata = cd;
    cam_req   = kr; cam_we = kw; cam_addr = {24'd0, ka}; cam_wdata = kd;
    model();
  endtask

  task automatic idle();
    drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
  endtask

  // Monitor: compares the DUT against whatever the model queued for this cycle.
  rd_t         mr;
  gt_t         mg;
  bit          exp_v;
  logic [31:0] cpu_last = '0;
  logic [31:0] cam_last = '0;
  always @(negedge clk) begin
    if (!reset) begin cpu_last = '0; cam_last = '0; end
    if (exp_g.size() > 0 && exp_g[0].due == cyc) begin
      mg = exp_g.pop_front();
      chk("cpu_stall", 32'(cpu_stall), 32'(mg.stall));
      chk("cam_gnt",   32'(cam_gnt),   32'(mg.gnt));
      chk("ram_wren",  32'(ram_wren),  32'(mg.wren));
    end
    exp_v = (exp_cpu.size() > 0) && (exp_cpu[0].due == cyc);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_v));
    if (exp_v) begin
      mr = exp_cpu.pop_front();
      chk("cpu_rdata", cpu_rdata, mr.data);
      cpu_last = mr.data;
    end else chk("cpu_rdata_hold", cpu_rdata, cpu_last);
    exp_v = (exp_cam.size() > 0) && (exp_cam[0].due == cyc);
    chk("cam_rvalid", 32'(cam_rvalid), 32'(exp_v));
    if (exp_v) begin
      mr = exp_cam.pop_front();
      chk("cam_rdata", cam_rdata, mr.data);
      cam_last = mr.data;
    end else chk("cam_rdata_hold", cam_rdata, cam_last);
    chk("rvalid_exclusive", 32'(cpu_rvalid && cam_rvalid), 32'd0);
  end

  initial begin
    bit          cr, cw, kr, kw;
    logic [7:0]  ca, ka;
    logic [31:0] cd, kd;
    int          ngnt, gidx;

    reset = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = '0; cpu_wdata = '0;
    cam_req = 1; cam_we = 1; cam_addr = '0; cam_wdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    // Reset with both requesters asserting: nothing may be granted or written.
    rst_val = 1'b0;
    drive(1, 1, 8'd1, 32'h1111_1111, 1, 1, 8'd2, 32'h2222_2222);
    drive(1, 1, 8'd1, 32'h1111_1111, 1, 1, 8'd2, 32'h2222_2222);
    #1;
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_cam_gnt",   32'(cam_gnt),   32'd0);
    chk("rst_ram_wren",  32'(ram_wren),  32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cam_rdata", cam_rdata, 32'd0);
    rst_val = 1'b1;
    idle(); idle();

    // CPU store then load of the same word.
    drive(1, 1, 8'd3, 32'hDEAD_BEEF, 0, 0, 8'd0, 32'd0);
    drive(1, 0, 8'd3, 32'd0,         0, 0, 8'd0, 32'd0);
    idle(); idle();

    // Contention for 12 cycles: only the guard may hand CAM a slot, and only at cycle LIMIT.
    ngnt = 0; gidx = -1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 8'd3, 32'd0, 1, 0, 8'd5, 32'd0);
      #1;
      if (cam_gnt) begin ngnt++; if (gidx < 0) gidx = i; end
    end
    chk("contention_cam_grants", 32'(ngnt), GUARD ? 32'd1 : 32'd0);
    chk("contention_gnt_cycle",  32'(gidx), GUARD ? 32'(LIMIT) : 32'hFFFF_FFFF);
    idle(); idle();

    // Alternating reads from the two owners.
    drive(1, 1, 8'd5, 32'h11, 0, 0, 8'd0, 32'd0);
    drive(0, 0, 8'd0, 32'd0,  1, 1, 8'd6, 32'h22);
    drive(1, 0, 8'd5, 32'd0,  0, 0, 8'd0, 32'd0);
    drive(0, 0, 8'd0, 32'd0,  1, 0, 8'd6, 32'd0);
    idle(); idle();

    // CAM write while CPU is idle, then CPU reads it back.
    drive(0, 0, 8'd0, 32'd0, 1, 1, 8'h40, 32'hA5A5_A5A5);
    #1;
    chk("cam_write_gnt", 32'(cam_gnt), 32'd1);
    drive(1, 0, 8'h40, 32'd0, 0, 0, 8'd0, 32'd0);
    idle(); idle();

    // Reset lands while a CPU load is in flight; its return must vanish.
    drive(1, 0, 8'd3, 32'd0, 0, 0, 8'd0, 32'd0);
    rst_val = 1'b0;
    idle();
    #1;
    chk("midread_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    idle();
    rst_val = 1'b1;
    idle(); idle(); idle();

    // Random traffic; each requester holds its request until the model says it was served.
    cr = 0; kr = 0; cw = 0; kw = 0; ca = '0; ka = '0; cd = '0; kd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(cr && last_win != 1)) begin
        cr = ($urandom_range(0, 99) < 60);
        cw = 1'($urandom_range(0, 1));
        ca = 8'($urandom_range(0, 15));
        cd = $urandom;
      end
      if (!(kr && last_win != 2)) begin
        kr = ($urandom_range(0, 99) < 50);
        kw = 1'($urandom_range(0, 1));
        ka = 8'($urandom_range(0, 15));
        kd = $urandom;
      end
      drive(cr, cw, ca, cd, kr, kw, ka, kd);
    end
    idle(); idle(); idle();
    #1;
    chk("scoreboard_drained", 32'(exp_cpu.size() + exp_cam.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM (32-bit, synchronous, 1-cycle read latency) between two requesters: the ARM core's memory stage (CPU) and the camera frame DMA (CAM).
- Sits between the core's WriteAddress/WriteData/write_enable/ReadData port and the RAM instance.
- Fixed CPU priority with a starvation guard for CAM.
- Tracks the owner of each outstanding read so that returned data is steered to the correct requester.

Parameters:
- AW, 32, address width of both requester ports and the RAM address.
- STARVE_LIMIT, 8, consecutive CAM-denied cycles after which CAM is forced a slot (range 1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU access not accepted this cycle; CPU must hold request
- cpu_rdata  out  32  load data
- cpu_rvalid  out  1  cpu_rdata valid (1 cycle after accepted load)
- cam_req  in  1  CAM access request, held until cam_gnt
- cam_we  in  1  1 = write pixel, 0 = read
- cam_addr  in  AW  CAM address
- cam_wdata  in  32  CAM write data
- cam_gnt  out  1  CAM access accepted this cycle
- cam_rdata  out  32  CAM read data
- cam_rvalid  out  1  cam_rdata valid
- ram_address  out  AW  to RAM address_a
- ram_data  out  32  to RAM data_a
- ram_wren  out  1  to RAM wren_a
- ram_q  in  32  from RAM q_a

Behaviour:
- Grant decision is combinational from the requests and registered state. RAM drive signals are a combinational mux of the winner's signals; the RAM registers them.
- Winner selection: if force_cam=1 and cam_req=1, CAM wins; else if cpu_req=1, CPU wins; else if cam_req=1, CAM wins; else none.
- Outputs per winner:
  - CPU wins: cpu_stall=0, cam_gnt=0.
  - CAM wins: cam_gnt=1, cpu_stall=cpu_req.
  - No winner: ram_wren=0, ram_address and ram_data hold the CPU signals, no read is tracked.
- ram_wren = winner's we while a winner exists, otherwise 0. The cycle-by-cycle mux is the sole RAM driver.
- Starvation counter (starve_cnt, 8-bit, reset 0):
  - Increments when cam_req=1 and CAM loses.
  - Clears to 0 on cam_gnt or when cam_req=0.
  - Saturates at STARVE_LIMIT.
  - force_cam = (starve_cnt == STARVE_LIMIT).
- Read return tracking, registered owner state rd_own ∈ {NONE, CPU, CAM}, reset NONE:
  - Set each cycle to the winner if the winner's we=0; otherwise NONE.
  - Next cycle, the rvalid of the owner is 1 and its rdata = ram_q.
  - The other requester's rvalid is 0 and its rdata is held.
- Back-to-back reads from alternating owners are allowed every cycle; the owner pipeline is 1 deep.
- Write latency: the write completes at the clock edge that accepts it. A read of the same address in the following cycle returns the new data.
- Reset (reset=0, asynchronous):
  - starve_cnt=0, rd_own=NONE.
  - cpu_rvalid=0, cam_rvalid=0, cpu_rdata=0, cam_rdata=0.
  - cam_gnt=0, ram_wren=0.
  - cpu_stall=cpu_req is allowed during reset only if a CAM grant is impossible; cam_gnt is forced 0, so cpu_stall=0.
- Reset asserted mid-read: the pending rvalid is dropped and is never produced after release.
- Simultaneous cpu_req and cam_req with starve_cnt below the limit: CPU wins and the counter increments.
- Simultaneous requests at the limit: CAM wins, cpu_stall=1, and the counter clears the next cycle.
- The CPU cannot be starved: after a forced CAM slot, the counter restarts from 0.

Optional Feature:
- Macro: RAM_ARBITER_STARVE_GUARD_EN.
- Defined: the starvation counter and force_cam behave as above.
- Undefined: the counter is not built and force_cam is constant 0. Arbitration is strict CPU priority; CAM is granted only in cycles with cpu_req=0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles then 1, no requests -> all rvalid=0, ram_wren=0, cam_gnt=0, cpu_stall=0.
- CPU store/load: CPU write 0xDEADBEEF to addr 3, next cycle CPU read addr 3 -> cpu_stall=0 both cycles; cpu_rvalid=1 one cycle later with cpu_rdata=0xDEADBEEF; cam_rvalid=0.
- Contention: cpu_req and cam_req both held for 12 cycles, STARVE_LIMIT=8, guard enabled -> CPU granted cycles 0–7, cam_gnt=1 and cpu_stall=1 at cycle 8, CPU granted again cycle 9. With guard disabled -> cam_gnt=0 for all 12 cycles.
- Alternating reads: CPU reads addr 5 (0x11), next cycle CAM reads addr 6 (0x22) -> cpu_rvalid with 0x11, then cam_rvalid with 0x22, never both set in the same cycle.
- CAM write while CPU idle: cam_req, cam_we=1, addr 0x40, data 0xA5A5A5A5 -> cam_gnt=1 same cycle; a following CPU read of 0x40 returns 0xA5A5A5A5.
- Reset mid-read: CPU load accepted, reset asserted before the next edge -> cpu_rvalid stays 0 and stays 0 after release.
